// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman input controller: controller states,
// default guess holdoff and the ASCII bounds used by the letter decoder.
package hangman_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_START   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_OVER    = 3'd3,
    ST_RESTART = 3'd4
  } state_t;

  localparam int HOLDOFF_DEFAULT = 8;

  localparam logic [7:0] ASCII_UPPER_A  = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z  = 8'h5A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  localparam int ALPHA_LEN = 26;
  localparam int WORD_LEN  = 5;

  localparam logic [2:0] WIN_COUNT  = 3'd5;
  localparam logic [2:0] LOSE_COUNT = 3'd6;

endpackage

// File: rtl/letter_decode.sv
// Keypad code to letter: folds lowercase onto uppercase, flags codes that are
// letters after folding and produces the one-hot alphabet index (bit0 = 'A').
module letter_decode
  import hangman_pkg::*;
(
  input  logic [7:0]  char,
  output logic [7:0]  letter,
  output logic        is_letter,
  output logic [25:0] idx_onehot
);

  logic [7:0] folded;
  logic [4:0] idx;

  // Fold case, range-check and build the one-hot index.
  always_comb begin
    folded = char;
    if ((char >= (ASCII_UPPER_A + ASCII_CASE_OFS)) &&
        (char <= (ASCII_UPPER_Z + ASCII_CASE_OFS)))
      folded = char - ASCII_CASE_OFS;
    is_letter  = (folded >= ASCII_UPPER_A) && (folded <= ASCII_UPPER_Z);
    idx        = 5'(folded - ASCII_UPPER_A);
    letter     = is_letter ? folded : 8'h00;
    idx_onehot = is_letter ? (26'd1 << idx) : 26'd0;
  end

endmodule

// File: rtl/game_input_ctrl.sv
// Hangman input controller: collects the secret word, starts the game,
// rate-limits and de-duplicates guesses, and latches the win/lose result.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ENTRY    | collecting up to five secret-word letters, waiting for submit
//   START    | toggle_state pulse; clear used mask, arm guess holdoff
//   PLAY     | accepting guesses, watching correct/incorrect for game end
//   OVER     | result held; only new_game leaves
//   RESTART  | gameEnd pulse; everything already cleared, back to ENTRY
module game_input_ctrl
  import hangman_pkg::*;
#(
  parameter int HOLDOFF = HOLDOFF_DEFAULT
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [7:0]  char,
  input  logic        char_valid,
  input  logic        submit,
  input  logic        new_game,
  input  logic        red_busy,
  input  logic [2:0]  correct,
  input  logic [2:0]  incorrect,
  output logic [39:0] setWord,
  output logic        toggle_state,
  output logic [7:0]  guess,
  output logic        gameEnd,
  output logic [25:0] used,
  output logic        dup,
  output logic        win,
  output logic        lose,
  output logic [2:0]  entry_cnt
);

  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

  state_t        state;
  logic [HW-1:0] holdoff;

  logic [7:0]    letter;
  logic          is_letter;
  logic [25:0]   idx_onehot;

  logic          letter_ok;
  logic          hold_zero;
  logic          game_done;
  logic          accept;
  logic          fresh;
  logic          repeat_hit;
  logic          hold_load;

  letter_decode u_decode (
    .char       (char),
    .letter     (letter),
    .is_letter  (is_letter),
    .idx_onehot (idx_onehot)
  );

  // Guess qualification. A letter arriving while dup is still high is dropped
  // so that dup can never stay asserted on back-to-back repeated guesses.
  always_comb begin
    letter_ok  = char_valid && is_letter;
    hold_zero  = (holdoff == '0);
    game_done  = hold_zero && ((correct == WIN_COUNT) || (incorrect == LOSE_COUNT));
    accept     = letter_ok && hold_zero && !red_busy && !dup;
    fresh      = accept && ((used & idx_onehot) == '0);
    repeat_hit = accept && !fresh;
    hold_load  = (state == ST_START) ||
                 ((state == ST_PLAY) && !game_done && fresh);
  end

  // Guess holdoff: down-counter that saturates at zero, reloaded on start and
  // on every new guess.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)
      holdoff <= '0;
    else if (new_game)
      holdoff <= '0;
    else if (hold_load)
      holdoff <= HOLD_LOAD;
    else if (!hold_zero)
      holdoff <= holdoff - HW'(1);
  end

  // Controller state and registered outputs; new_game overrides everything.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state        <= ST_ENTRY;
      setWord      <= '0;
      toggle_state <= 1'b0;
      guess        <= '0;
      gameEnd      <= 1'b0;
      used         <= '0;
      dup          <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
      entry_cnt    <= '0;
    end else begin
      toggle_state <= 1'b0;
      gameEnd      <= 1'b0;
      dup          <= 1'b0;
      if (new_game) begin
        // A repeated new_game while already restarting does not re-pulse.
        state     <= ST_RESTART;
        gameEnd   <= (state != ST_RESTART);
        setWord   <= '0;
        guess     <= '0;
        used      <= '0;
        entry_cnt <= '0;
        win       <= 1'b0;
        lose      <= 1'b0;
      end else begin
        case (state)
          ST_ENTRY: begin
            if (letter_ok && (entry_cnt < 3'(WORD_LEN))) begin
              setWord   <= {setWord[31:0], letter};
              entry_cnt <= entry_cnt + 3'd1;
            end
            if (submit && (entry_cnt == 3'(WORD_LEN))) begin
              state        <= ST_START;
              toggle_state <= 1'b1;
            end
          end
          ST_START: begin
            guess <= '0;
            used  <= '0;
            state <= ST_PLAY;
          end
          ST_PLAY: begin
            if (game_done) begin
              state <= ST_OVER;
              if (correct == WIN_COUNT)
                win <= 1'b1;
              else
                lose <= 1'b1;
            end else if (fresh) begin
              guess <= letter;
              used  <= used | idx_onehot;
            end else if (repeat_hit) begin
              dup <= 1'b1;
            end
          end
          ST_OVER: begin
            state <= ST_OVER;
          end
          ST_RESTART: begin
            state <= ST_ENTRY;
          end
          default: begin
            state <= ST_ENTRY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_input_ctrl.sv
// Bench for game_input_ctrl: directed vector table, a mid-game reset
// sequence and a randomized run, all checked against a behavioural model.
module tb_game_input_ctrl;

  localparam int HOLDOFF = 8;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [7:0]  ch = 8'h00;
  logic        char_valid = 1'b0;
  logic        submit = 1'b0;
  logic        new_game = 1'b0;
  logic        red_busy = 1'b0;
  logic [2:0]  correct = 3'd0;
  logic [2:0]  incorrect = 3'd0;
  logic [39:0] setWord;
  logic        toggle_state;
  logic [7:0]  guess;
  logic        gameEnd;
  logic [25:0] used;
  logic        dup;
  logic        win;
  logic        lose;
  logic [2:0]  entry_cnt;

  game_input_ctrl #(.HOLDOFF(HOLDOFF)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .char         (ch),
    .char_valid   (char_valid),
    .submit       (submit),
    .new_game     (new_game),
    .red_busy     (red_busy),
    .correct      (correct),
    .incorrect    (incorrect),
    .setWord      (setWord),
    .toggle_state (toggle_state),
    .guess        (guess),
    .gameEnd      (gameEnd),
    .used         (used),
    .dup          (dup),
    .win          (win),
    .lose         (lose),
    .entry_cnt    (entry_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_ENTRY, M_START, M_PLAY, M_OVER, M_RESTART} mphase_t;
  mphase_t      m_phase;
  byte unsigned m_word[$];
  bit           m_guessed[26];
  int           m_hold;
  logic [7:0]   m_guess;
  bit           m_toggle, m_end, m_dup, m_win, m_lose;

  function automatic void model_reset();
    m_phase = M_ENTRY;
    m_word.delete();
    foreach (m_guessed[i]) m_guessed[i] = 1'b0;
    m_hold = 0;
    m_guess = 8'h00;
    m_toggle = 0; m_end = 0; m_dup = 0; m_win = 0; m_lose = 0;
  endfunction

  function automatic void model_step();
    int f;
    bit is_l;
    int idx;
    bit prev_dup;
    int hold_now;
    f = int'(ch);
    if (f >= 'h61 && f <= 'h7A) f = f - 'h20;
    is_l = (f >= 'h41 && f <= 'h5A);
    idx = f - 'h41;
    prev_dup = m_dup;
    hold_now = m_hold;
    m_toggle = 0; m_end = 0; m_dup = 0;
    if (m_hold > 0) m_hold = m_hold - 1;
    if (new_game) begin
      m_end = (m_phase != M_RESTART);
      m_phase = M_RESTART;
      m_word.delete();
      foreach (m_guessed[i]) m_guessed[i] = 1'b0;
      m_guess = 8'h00; m_win = 0; m_lose = 0; m_hold = 0;
    end else begin
      case (m_phase)
        M_ENTRY: begin
          if (submit && m_word.size() == 5) begin
            m_phase = M_START;
            m_toggle = 1;
          end
          if (char_valid && is_l && m_word.size() < 5) m_word.push_back(8'(f));
        end
        M_START: begin
          foreach (m_guessed[i]) m_guessed[i] = 1'b0;
          m_guess = 8'h00;
          m_hold = HOLDOFF;
          m_phase = M_PLAY;
        end
        M_PLAY: begin
          if (hold_now == 0 && (correct == 3'd5 || incorrect == 3'd6)) begin
            m_phase = M_OVER;
            if (correct == 3'd5) m_win = 1; else m_lose = 1;
          end else if (char_valid && is_l && hold_now == 0 && !red_busy && !prev_dup) begin
            if (m_guessed[idx]) m_dup = 1;
            else begin
              m_guessed[idx] = 1'b1;
              m_guess = 8'(f);
              m_hold = HOLDOFF;
            end
          end
        end
        M_OVER: ;
        M_RESTART: m_phase = M_ENTRY;
        default: m_phase = M_ENTRY;
      endcase
    end
  endfunction

  task automatic model_check();
    logic [39:0] w;
    logic [25:0] u;
    w = '0;
    u = '0;
    foreach (m_word[i]) w = {w[31:0], m_word[i]};
    for (int i = 0; i < 26; i++) u[i] = m_guessed[i];
    check("setWord", setWord, w);
    check("entry_cnt", entry_cnt, m_word.size());
    check("toggle_state", toggle_state, m_toggle);
    check("guess", guess, m_guess);
    check("used", used, u);
    check("dup", dup, m_dup);
    check("gameEnd", gameEnd, m_end);
    check("win", win, m_win);
    check("lose", lose, m_lose);
  endtask

  task automatic step();
    @(posedge clk);
    if (!nRst) model_reset(); else model_step();
    #1;
    model_check();
  endtask

  task automatic apply(input logic [7:0] c, input logic cv, input logic sb, input logic ng,
                       input logic rb, input logic [2:0] cor, input logic [2:0] inc);
    ch = c; char_valid = cv; submit = sb; new_game = ng; red_busy = rb;
    correct = cor; incorrect = inc;
    step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0]  c;
    logic        cv, sb, ng, rb;
    logic [2:0]  cor, inc;
    logic [39:0] sw;
    logic [2:0]  ec;
    logic        tg;
    logic [7:0]  gs;
    logic [25:0] us;
    logic        dp, ge, wn, ls;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] c, input logic cv, input logic sb, input logic ng,
                              input logic rb, input logic [2:0] cor, input logic [2:0] inc,
                              input logic [39:0] sw, input logic [2:0] ec, input logic tg,
                              input logic [7:0] gs, input logic [25:0] us, input logic dp,
                              input logic ge, input logic wn, input logic ls);
    vec_t v;
    v.c = c; v.cv = cv; v.sb = sb; v.ng = ng; v.rb = rb; v.cor = cor; v.inc = inc;
    v.sw = sw; v.ec = ec; v.tg = tg; v.gs = gs; v.us = us;
    v.dp = dp; v.ge = ge; v.wn = wn; v.ls = ls;
    vecs.push_back(v);
  endfunction

  localparam logic [39:0] HELLO = 40'h48454C4C4F;

  initial begin
    //   char  cv sb ng rb cor inc | setWord          ec tg guess  used      dp ge wn ls
    add(8'h68, 1, 0, 0, 0, 0, 0,  40'h48,           1, 0, 8'h00, 26'h000, 0, 0, 0, 0);
    add(8'h65, 1, 0, 0, 0, 0, 0,  40'h4845,         2, 0, 8'h00, 26'h000, 0, 0, 0, 0);
    add(8'h6C, 1, 0, 0, 0, 0, 0,  40'h48454C,       3, 0, 8'h00, 26'h000, 0, 0, 0, 0);
    add(8'h00, 0, 1, 0, 0, 0, 0,  40'h48454C,       3, 0, 8'h00, 26'h000, 0, 0, 0, 0);
    add(8'h6C, 1, 0, 0, 0, 0, 0,  40'h48454C4C,     4, 0, 8'h00, 26'h000, 0, 0, 0, 0);
    add(8'h6F, 1, 0, 0, 0, 0, 0,  HELLO,            5, 0, 8'h00, 26'h000, 0, 0, 0, 0);
    add(8'h78, 1, 0, 0, 0, 0, 0,  HELLO,            5, 0, 8'h00, 26'h000, 0, 0, 0, 0);
    add(8'h35, 1, 0, 0, 0, 0, 0,  HELLO,            5, 0, 8'h00, 26'h000, 0, 0, 0, 0);
    add(8'h00, 0, 1, 0, 0, 0, 0,  HELLO,            5, 1, 8'h00, 26'h000, 0, 0, 0, 0);
    add(8'h00, 0, 0, 0, 0, 0, 0,  HELLO,            5, 0, 8'h00, 26'h000, 0, 0, 0, 0);
    add(8'h61, 1, 0, 0, 0, 0, 0,  HELLO,            5, 0, 8'h00, 26'h000, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      add(8'h00, 0, 0, 0, 0, 0, 0, HELLO,           5, 0, 8'h00, 26'h000, 0, 0, 0, 0);
    add(8'h6C, 1, 0, 0, 0, 0, 0,  HELLO,            5, 0, 8'h4C, 26'h800, 0, 0, 0, 0);
    add(8'h00, 0, 0, 0, 0, 0, 0,  HELLO,            5, 0, 8'h4C, 26'h800, 0, 0, 0, 0);
    add(8'h00, 0, 0, 0, 0, 0, 0,  HELLO,            5, 0, 8'h4C, 26'h800, 0, 0, 0, 0);
    add(8'h62, 1, 0, 0, 0, 0, 0,  HELLO,            5, 0, 8'h4C, 26'h800, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      add(8'h00, 0, 0, 0, 0, 0, 0, HELLO,           5, 0, 8'h4C, 26'h800, 0, 0, 0, 0);
    add(8'h62, 1, 0, 0, 1, 0, 0,  HELLO,            5, 0, 8'h4C, 26'h800, 0, 0, 0, 0);
    add(8'h4C, 1, 0, 0, 0, 0, 0,  HELLO,            5, 0, 8'h4C, 26'h800, 1, 0, 0, 0);
    add(8'h00, 0, 0, 0, 0, 0, 0,  HELLO,            5, 0, 8'h4C, 26'h800, 0, 0, 0, 0);
    add(8'h65, 1, 0, 0, 0, 0, 0,  HELLO,            5, 0, 8'h45, 26'h810, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(8'h00, 0, 0, 0, 0, 5, 6, HELLO,           5, 0, 8'h45, 26'h810, 0, 0, 0, 0);
    add(8'h00, 0, 0, 0, 0, 5, 6,  HELLO,            5, 0, 8'h45, 26'h810, 0, 0, 1, 0);
    add(8'h7A, 1, 1, 0, 0, 0, 0,  HELLO,            5, 0, 8'h45, 26'h810, 0, 0, 1, 0);
    add(8'h41, 1, 0, 1, 0, 0, 0,  40'h0,            0, 0, 8'h00, 26'h000, 0, 1, 0, 0);
    add(8'h00, 0, 0, 0, 0, 0, 0,  40'h0,            0, 0, 8'h00, 26'h000, 0, 0, 0, 0);
    add(8'h71, 1, 0, 0, 0, 0, 0,  40'h51,           1, 0, 8'h00, 26'h000, 0, 0, 0, 0);

    // Reset state.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    model_check();
    check("rst_gameEnd", gameEnd, 1'b0);
    nRst = 1'b1;

    // Directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].c, vecs[i].cv, vecs[i].sb, vecs[i].ng, vecs[i].rb, vecs[i].cor, vecs[i].inc);
      check($sformatf("v%0d_setWord", i), setWord, vecs[i].sw);
      check($sformatf("v%0d_entry_cnt", i), entry_cnt, vecs[i].ec);
      check($sformatf("v%0d_toggle", i), toggle_state, vecs[i].tg);
      check($sformatf("v%0d_guess", i), guess, vecs[i].gs);
      check($sformatf("v%0d_used", i), used, vecs[i].us);
      check($sformatf("v%0d_dup", i), dup, vecs[i].dp);
      check($sformatf("v%0d_gameEnd", i), gameEnd, vecs[i].ge);
      check($sformatf("v%0d_win", i), win, vecs[i].wn);
      check($sformatf("v%0d_lose", i), lose, vecs[i].ls);
    end

    // Mid-game reset: finish the word "QUIZS", play one guess, pulse nRst.
    apply(8'h55, 1, 0, 0, 0, 0, 0);
    apply(8'h49, 1, 0, 0, 0, 0, 0);
    apply(8'h5A, 1, 0, 0, 0, 0, 0);
    apply(8'h53, 1, 0, 0, 0, 0, 0);
    apply(8'h00, 0, 1, 0, 0, 0, 0);
    check("mid_toggle", toggle_state, 1'b1);
    for (int i = 0; i < HOLDOFF + 1; i++) apply(8'h00, 0, 0, 0, 0, 0, 0);
    apply(8'h71, 1, 0, 0, 0, 0, 0);
    check("mid_guess", guess, 8'h51);
    apply(8'h00, 0, 0, 0, 0, 0, 0);
    #2;
    nRst = 1'b0;
    #1;
    model_reset();
    model_check();
    check("async_rst_guess", guess, 8'h00);
    check("async_rst_setWord", setWord, 40'h0);
    step();
    step();
    nRst = 1'b1;
    apply(8'h00, 0, 0, 0, 0, 0, 0);
    check("post_rst_gameEnd", gameEnd, 1'b0);

    // Randomized run against the model.
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [7:0] c;
      r = $urandom_range(0, 9);
      if (r < 4)      c = 8'(8'h41 + $urandom_range(0, 7));
      else if (r < 7) c = 8'(8'h61 + $urandom_range(0, 25));
      else            c = 8'($urandom_range(0, 255));
      ch         = c;
      char_valid = ($urandom_range(0, 1) == 0);
      submit     = ($urandom_range(0, 5) == 0);
      new_game   = ($urandom_range(0, 299) == 0);
      red_busy   = ($urandom_range(0, 3) == 0);
      correct    = ($urandom_range(0, 119) == 0) ? 3'd5 : 3'($urandom_range(0, 4));
      incorrect  = ($urandom_range(0, 119) == 0) ? 3'd6 : 3'($urandom_range(0, 5));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
